// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset controller.
// Registered FSM state with combinational (Moore) datapath controls. irwrite and
// pcen follow memready and zero within the cycle. Reset is asynchronous and
// forces FETCH immediately, with every write enable held low.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       alusrca,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       pcen,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t     r_state;

  logic       w_op_legal;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irfetch;
  logic       w_valid_state;
  logic       w_funct_bad;
  logic [1:0] w_aluop;
  logic [2:0] w_alucontrol;

  // Opcodes the controller knows how to sequence; anything else is flagged in DECODE.
  always_comb begin
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
      default:                                       w_op_legal = 1'b0;
    endcase
  end

  // State register: memready is only consulted in FETCH, MEMRD and MEMWR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (memready) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEXEC;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    if (memready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWR:    if (memready) r_state <= S_FETCH;
        S_EXECUTE:  r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_ADDIEXEC: r_state <= S_ADDIWB;
        S_ADDIWB:   r_state <= S_FETCH;
        S_JUMP:     r_state <= S_FETCH;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the per-state datapath controls; unlisted controls stay 0.
  always_comb begin
    iord          = 1'b0;
    alusrca       = 1'b0;
    memwrite      = 1'b0;
    regwrite      = 1'b0;
    regdst        = 1'b0;
    memtoreg      = 1'b0;
    alusrcb       = 2'b00;
    pcsrc         = 2'b00;
    w_aluop       = 2'b00;
    w_pcwrite     = 1'b0;
    w_branch      = 1'b0;
    w_irfetch     = 1'b0;
    w_valid_state = 1'b1;
    case (r_state)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irfetch = 1'b1;
      end
      S_DECODE:   alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:    iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:   regwrite = 1'b1;
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default:    w_valid_state = 1'b0;
    endcase
  end

  // ALU decoder: fixed add/subtract for address and branch work, funct for R-type.
  always_comb begin
    w_alucontrol = 3'b010;
    w_funct_bad  = 1'b0;
    case (w_aluop)
      2'b00: w_alucontrol = 3'b010;
      2'b01: w_alucontrol = 3'b110;
      default: begin
        case (funct)
          6'b100000: w_alucontrol = 3'b010;
          6'b100010: w_alucontrol = 3'b110;
          6'b100100: w_alucontrol = 3'b000;
          6'b100101: w_alucontrol = 3'b001;
          6'b101010: w_alucontrol = 3'b111;
          default: begin
            w_alucontrol = 3'b010;
            w_funct_bad  = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Mealy-style terms are masked by reset so nothing writes while it is held.
  always_comb begin
    alucontrol = w_valid_state ? w_alucontrol : 3'b000;
    irwrite    = ~reset & w_irfetch & memready;
    pcen       = ~reset & ((w_pcwrite | (w_irfetch & memready)) | (w_branch & zero));
    illegal_op = ~reset & (((r_state == S_DECODE) & ~w_op_legal) |
                           ((r_state == S_EXECUTE) & w_funct_bad));
    state      = r_state;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction's expected
// per-cycle state and control vector is queued up front, then popped and
// compared on the falling edge of every cycle.
module tb_multicycle_controller;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal_op;
  logic [3:0] state;
  logic [15:0] w_vec;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [3:0] st; logic mr; } stim_t;
  typedef struct packed { logic [3:0] st; logic [15:0] vec; } exp_t;
  stim_t stim_q[$];
  exp_t  sb_q[$];

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord), .alusrca(alusrca), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .pcen(pcen),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal_op(illegal_op), .state(state)
  );

  assign w_vec = {iord, alusrca, irwrite, memwrite, regwrite, regdst, memtoreg, pcen,
                  alusrcb, pcsrc, alucontrol, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected controls for a state, straight from the per-state output table.
  function automatic logic [15:0] out_for(input logic [3:0] st, input logic [5:0] o,
                                          input logic [5:0] f, input logic z, input logic mr);
    logic e_iord, e_srca, e_irw, e_memw, e_regw, e_rdst, e_m2r, e_pcen, e_ill;
    logic [1:0] e_srcb, e_psrc;
    logic [2:0] e_aluc;
    {e_iord, e_srca, e_irw, e_memw, e_regw, e_rdst, e_m2r, e_pcen, e_ill} = '0;
    e_srcb = 2'b00;
    e_psrc = 2'b00;
    e_aluc = 3'b010;
    case (st)
      4'd0:  begin e_srcb = 2'b01; e_irw = mr; e_pcen = mr; end
      4'd1:  begin
        e_srcb = 2'b11;
        e_ill  = !(o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
      end
      4'd2:  begin e_srca = 1'b1; e_srcb = 2'b10; end
      4'd3:  e_iord = 1'b1;
      4'd4:  begin e_m2r = 1'b1; e_regw = 1'b1; end
      4'd5:  begin e_iord = 1'b1; e_memw = 1'b1; end
      4'd6:  begin
        e_srca = 1'b1;
        case (f)
          6'b100000: e_aluc = 3'b010;
          6'b100010: e_aluc = 3'b110;
          6'b100100: e_aluc = 3'b000;
          6'b100101: e_aluc = 3'b001;
          6'b101010: e_aluc = 3'b111;
          default:   e_ill  = 1'b1;
        endcase
      end
      4'd7:  begin e_rdst = 1'b1; e_regw = 1'b1; end
      4'd8:  begin e_srca = 1'b1; e_aluc = 3'b110; e_psrc = 2'b01; e_pcen = z; end
      4'd9:  begin e_srca = 1'b1; e_srcb = 2'b10; end
      4'd10: e_regw = 1'b1;
      4'd11: begin e_psrc = 2'b10; e_pcen = 1'b1; end
      default: e_aluc = 3'b000;
    endcase
    return {e_iord, e_srca, e_irw, e_memw, e_regw, e_rdst, e_m2r, e_pcen,
            e_srcb, e_psrc, e_aluc, e_ill};
  endfunction

  // Queue one cycle of stimulus together with its expected result.
  task automatic add(input logic [3:0] st, input logic mr);
    exp_t e;
    stim_q.push_back('{st: st, mr: mr});
    e.st  = st;
    e.vec = out_for(st, op, funct, zero, mr);
    sb_q.push_back(e);
  endtask

  // Play queued cycles, comparing on the falling edge of each.
  task automatic run_queue(input string name);
    stim_t s;
    exp_t  e;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      memready = s.mr;
      @(negedge clk);
      e = sb_q.pop_front();
      chk({name, ".state"}, 32'(state), 32'(e.st));
      chk({name, ".ctrl"}, 32'(w_vec), 32'(e.vec));
      @(posedge clk);
      #1;
    end
  endtask

  // Build the expected state walk of one instruction, then run it.
  task automatic exec_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int fw, input int mw);
    op    = o;
    funct = f;
    zero  = z;
    repeat (fw) add(4'd0, 1'b0);
    add(4'd0, 1'b1);
    add(4'd1, 1'($urandom_range(0, 1)));
    case (o)
      OP_LW: begin
        add(4'd2, 1'($urandom_range(0, 1)));
        repeat (mw) add(4'd3, 1'b0);
        add(4'd3, 1'b1);
        add(4'd4, 1'($urandom_range(0, 1)));
      end
      OP_SW: begin
        add(4'd2, 1'($urandom_range(0, 1)));
        repeat (mw) add(4'd5, 1'b0);
        add(4'd5, 1'b1);
      end
      OP_RTYPE: begin
        add(4'd6, 1'($urandom_range(0, 1)));
        add(4'd7, 1'($urandom_range(0, 1)));
      end
      OP_ADDI: begin
        add(4'd9, 1'($urandom_range(0, 1)));
        add(4'd10, 1'($urandom_range(0, 1)));
      end
      OP_BEQ:  add(4'd8, 1'($urandom_range(0, 1)));
      OP_J:    add(4'd11, 1'($urandom_range(0, 1)));
      default: ;
    endcase
    run_queue(name);
    $display("txn %s op=%b funct=%b zero=%0b done, checks=%0d fails=%0d",
             name, o, f, z, n_checks, n_fail);
  endtask

  initial begin
    reset    = 1'b1;
    op       = 6'd0;
    funct    = 6'd0;
    zero     = 1'b0;
    memready = 1'b1;
    #2;
    chk("reset.state", 32'(state), 32'd0);
    chk("reset.ctrl", 32'(w_vec), 32'(out_for(4'd0, op, funct, zero, 1'b0)));
    @(posedge clk);
    #1;
    reset = 1'b0;

    exec_instr("lw", OP_LW, 6'b000000, 1'b0, 0, 0);
    exec_instr("lw_wait", OP_LW, 6'b010101, 1'b1, 2, 2);
    exec_instr("sw_wait3", OP_SW, 6'b000000, 1'b0, 0, 3);
    exec_instr("slt", OP_RTYPE, 6'b101010, 1'b0, 0, 0);
    exec_instr("add", OP_RTYPE, 6'b100000, 1'b1, 1, 0);
    exec_instr("sub", OP_RTYPE, 6'b100010, 1'b0, 0, 0);
    exec_instr("and", OP_RTYPE, 6'b100100, 1'b0, 0, 0);
    exec_instr("or", OP_RTYPE, 6'b100101, 1'b0, 0, 0);
    exec_instr("bad_funct", OP_RTYPE, 6'b111111, 1'b0, 0, 0);
    exec_instr("addi", OP_ADDI, 6'b100010, 1'b0, 0, 0);
    exec_instr("beq_taken", OP_BEQ, 6'b000000, 1'b1, 0, 0);
    exec_instr("beq_not", OP_BEQ, 6'b000000, 1'b0, 0, 0);
    exec_instr("j", OP_J, 6'b000000, 1'b1, 0, 0);
    exec_instr("bad_op", 6'b111111, 6'b000000, 1'b0, 0, 0);
    exec_instr("bad_op2", 6'b000001, 6'b101010, 1'b1, 1, 0);

    // Abandon a store stalled in MEMWR with an asynchronous reset.
    op    = OP_SW;
    funct = 6'd0;
    zero  = 1'b0;
    add(4'd0, 1'b1);
    add(4'd1, 1'b1);
    add(4'd2, 1'b0);
    add(4'd5, 1'b0);
    run_queue("sw_pre_rst");
    #2;
    chk("rst_pre.state", 32'(state), 32'd5);
    chk("rst_pre.memwrite", 32'(memwrite), 32'd1);
    memready = 1'b1;
    reset    = 1'b1;
    #1;
    chk("rst_async.state", 32'(state), 32'd0);
    chk("rst_async.ctrl", 32'(w_vec), 32'(out_for(4'd0, op, funct, zero, 1'b0)));
    @(posedge clk);
    #1;
    chk("rst_hold.state", 32'(state), 32'd0);
    chk("rst_hold.ctrl", 32'(w_vec), 32'(out_for(4'd0, op, funct, zero, 1'b0)));
    reset = 1'b0;
    $display("txn sw_reset op=%b done, checks=%0d fails=%0d", op, n_checks, n_fail);

    exec_instr("lw_post_rst", OP_LW, 6'b000000, 1'b0, 0, 1);
    exec_instr("j_post_rst", OP_J, 6'b000000, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
